// File: rtl/round_sat_pipe_if.sv
// Streaming handshake bundle for round_sat_pipe: one input sample channel and one output channel.
interface round_sat_pipe_if #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 16,
    parameter int SH_W  = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  in_data;
    logic [SH_W-1:0]  in_shift;
    logic [1:0]       in_mode;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_data;
    logic             out_sat;

    modport slave (
        input  in_valid, in_data, in_shift, in_mode, out_ready,
        output in_ready, out_valid, out_data, out_sat
    );

    modport master (
        output in_valid, in_data, in_shift, in_mode, out_ready,
        input  in_ready, out_valid, out_data, out_sat
    );
endinterface

// File: rtl/round_sat_pipe.sv
// Two-stage signed round-and-saturate unit: S1 shifts and decides the increment,
// S2 adds, clips to OUT_W and accounts overflow events. Valid/ready with bubble collapse.
module round_sat_pipe #(
    parameter int IN_W      = 16,
    parameter int OUT_W     = 16,
    parameter int MAX_SHIFT = 8,
    parameter int SH_W      = 4,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    round_sat_pipe_if.slave  s,
    input  logic             clr_ovf,
    output logic             ovf_sticky,
    output logic [CNT_W-1:0] ovf_count
);
    localparam logic signed [IN_W:0] C_MAX = {{(IN_W-OUT_W+2){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [IN_W:0] C_MIN = {{(IN_W-OUT_W+2){1'b1}}, {(OUT_W-1){1'b0}}};

    logic [2:1]              r_vld_pipe;
    logic signed [IN_W-1:0]  r_q;
    logic                    r_inc;
    logic [OUT_W-1:0]        r_data;
    logic                    r_sat;
    logic                    r_sticky;
    logic [CNT_W-1:0]        r_cnt;

    logic                    w_en1, w_en2;
    logic [SH_W-1:0]         w_s;
    logic [IN_W-1:0]         w_one, w_mask, w_r, w_half;
    logic signed [IN_W-1:0]  w_q;
    logic                    w_inc;
    logic signed [IN_W:0]    w_sum;
    logic                    w_hi, w_lo, w_sat;
    logic [OUT_W-1:0]        w_res;

    assign w_en2      = !r_vld_pipe[2] || s.out_ready;
    assign w_en1      = !r_vld_pipe[1] || w_en2;
    assign s.in_ready = w_en1;

    assign w_s    = (s.in_shift > SH_W'(MAX_SHIFT)) ? SH_W'(MAX_SHIFT) : s.in_shift;
    assign w_one  = IN_W'(1);
    assign w_mask = (w_one << w_s) - w_one;
    assign w_r    = s.in_data & w_mask;
    assign w_half = (w_one << w_s) >> 1;
    assign w_q    = $signed(s.in_data) >>> w_s;

    // With s=0 there is no fraction, so every mode must pass the sample unchanged.
    always_comb begin
        w_inc = 1'b0;
        if (w_s != '0) begin
            case (s.in_mode)
                2'd1:    w_inc = (w_r >= w_half);
                2'd2:    w_inc = (w_r > w_half) || ((w_r == w_half) && w_q[0]);
                2'd3:    w_inc = s.in_data[IN_W-1] && (w_r != '0);
                default: w_inc = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_vld_pipe[1] <= 1'b0;
            r_q           <= '0;
            r_inc         <= 1'b0;
        end else if (w_en1) begin
            r_vld_pipe[1] <= s.in_valid;
            if (s.in_valid) begin
                r_q   <= w_q;
                r_inc <= w_inc;
            end
        end
    end

    // One extra bit of headroom keeps q+1 from wrapping at the top of the input range.
    assign w_sum = $signed({r_q[IN_W-1], r_q}) + $signed({{IN_W{1'b0}}, r_inc});
    assign w_hi  = (w_sum > C_MAX);
    assign w_lo  = (w_sum < C_MIN);
    assign w_sat = w_hi || w_lo;
    assign w_res = w_hi ? {1'b0, {(OUT_W-1){1'b1}}} :
                   w_lo ? {1'b1, {(OUT_W-1){1'b0}}} : w_sum[OUT_W-1:0];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_vld_pipe[2] <= 1'b0;
            r_data        <= '0;
            r_sat         <= 1'b0;
        end else if (w_en2) begin
            r_vld_pipe[2] <= r_vld_pipe[1];
            if (r_vld_pipe[1]) begin
                r_data <= w_res;
                r_sat  <= w_sat;
            end
        end
    end

    // Events are taken on S2 load so a stalled sample is never counted twice.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sticky <= 1'b0;
            r_cnt    <= '0;
        end else if (clr_ovf) begin
            r_sticky <= 1'b0;
            r_cnt    <= '0;
        end else if (w_en2 && r_vld_pipe[1] && w_sat) begin
            r_sticky <= 1'b1;
            if (~&r_cnt) r_cnt <= r_cnt + 1'b1;
        end
    end

    assign s.out_valid = r_vld_pipe[2];
    assign s.out_data  = r_data;
    assign s.out_sat   = r_sat;
    assign ovf_sticky  = r_sticky;
    assign ovf_count   = r_cnt;
endmodule

// File: tb/tb_round_sat_pipe.sv
// Directed bench: default-width unit (A) and OUT_W=14 unit (B) fed the same stream.
module tb_round_sat_pipe;
    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid, out_ready, clr_ovf;
    logic [15:0] in_data;
    logic [3:0]  in_shift;
    logic [1:0]  in_mode;
    logic        ovf_sticky_a, ovf_sticky_b;
    logic [15:0] ovf_count_a, ovf_count_b;
    int          nvec = 0;
    int          nfail = 0;

    round_sat_pipe_if #(.IN_W(16), .OUT_W(16), .SH_W(4)) ifa ();
    round_sat_pipe_if #(.IN_W(16), .OUT_W(14), .SH_W(4)) ifb ();

    assign ifa.in_valid  = in_valid;
    assign ifa.in_data   = in_data;
    assign ifa.in_shift  = in_shift;
    assign ifa.in_mode   = in_mode;
    assign ifa.out_ready = out_ready;
    assign ifb.in_valid  = in_valid;
    assign ifb.in_data   = in_data;
    assign ifb.in_shift  = in_shift;
    assign ifb.in_mode   = in_mode;
    assign ifb.out_ready = out_ready;

    round_sat_pipe u_a (
        .clk(clk), .reset_n(reset_n), .s(ifa.slave), .clr_ovf(clr_ovf),
        .ovf_sticky(ovf_sticky_a), .ovf_count(ovf_count_a)
    );

    round_sat_pipe #(.OUT_W(14)) u_b (
        .clk(clk), .reset_n(reset_n), .s(ifb.slave), .clr_ovf(clr_ovf),
        .ovf_sticky(ovf_sticky_b), .ovf_count(ovf_count_b)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got running expected finished");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One isolated sample: no output after 1 clock, result after exactly 2.
    task automatic run1(input string tag, input int d, input int sh, input int md,
                        input int ea, input int eb, input int sb, input bit clr_mid);
        @(negedge clk);
        in_valid = 1'b1; in_data = 16'(d); in_shift = 4'(sh); in_mode = 2'(md);
        @(negedge clk);
        in_valid = 1'b0; clr_ovf = clr_mid;
        chk({tag, " lat1"}, 32'(ifa.out_valid), 0);
        @(negedge clk);
        clr_ovf = 1'b0;
        chk({tag, " vld"}, 32'(ifa.out_valid), 1);
        chk({tag, " a"}, $signed(ifa.out_data), ea);
        chk({tag, " b"}, $signed(ifb.out_data), eb);
        chk({tag, " bsat"}, 32'(ifb.out_sat), sb);
    endtask

    initial begin
        int td[7] = '{7, -7, 10, 14, 384, -6, 100};
        int ts[7] = '{2,  3,  1,  2,  15,  2,   0};
        int tm[7] = '{1,  3,  2,  2,   1,  1,   1};
        int te[7] = '{2,  0,  5,  4,   2, -1, 100};
        bit pat[8] = '{1, 0, 0, 1, 0, 1, 1, 0};
        bit mv1, mv2, e1, e2, held_v, exp_rdy;
        int nsent, nrecv;
        logic signed [31:0] held_d;

        reset_n = 1'b0; in_valid = 1'b0; in_data = '0; in_shift = '0; in_mode = '0;
        out_ready = 1'b1; clr_ovf = 1'b0;
        #12;
        chk("rst out_valid", 32'(ifa.out_valid), 0);
        chk("rst out_data", $signed(ifa.out_data), 0);
        chk("rst out_sat", 32'(ifb.out_sat), 0);
        chk("rst sticky", 32'(ovf_sticky_b), 0);
        chk("rst count", 32'(ovf_count_b), 0);
        @(negedge clk); reset_n = 1'b1;
        @(negedge clk);
        chk("post-rst in_ready", 32'(ifa.in_ready), 1);

        run1("m0 +7",  7, 2, 0,  1,  1, 0, 1'b0);
        run1("m1 +7",  7, 2, 1,  2,  2, 0, 1'b0);
        run1("m2 +7",  7, 2, 2,  2,  2, 0, 1'b0);
        run1("m3 +7",  7, 2, 3,  1,  1, 0, 1'b0);
        run1("m0 -7", -7, 2, 0, -2, -2, 0, 1'b0);
        run1("m1 -7", -7, 2, 1, -2, -2, 0, 1'b0);
        run1("m2 -7", -7, 2, 2, -2, -2, 0, 1'b0);
        run1("m3 -7", -7, 2, 3, -1, -1, 0, 1'b0);
        run1("tie m2 10", 10, 2, 2, 2, 2, 0, 1'b0);
        run1("tie m2 14", 14, 2, 2, 4, 4, 0, 1'b0);
        run1("tie m2 -6", -6, 2, 2, -2, -2, 0, 1'b0);
        run1("tie m1 10", 10, 2, 1, 3, 3, 0, 1'b0);
        run1("tie m1 -6", -6, 2, 1, -1, -1, 0, 1'b0);
        run1("tie m3 -6", -6, 2, 3, -1, -1, 0, 1'b0);
        run1("clamp 384", 384, 15, 1, 2, 2, 0, 1'b0);

        run1("sat max", 32767, 2, 1, 8192, 8191, 1, 1'b0);
        chk("sat max sticky", 32'(ovf_sticky_b), 1);
        chk("sat max count", 32'(ovf_count_b), 1);
        chk("wide no sat", 32'(ifa.out_sat), 0);
        run1("sat min", -32768, 0, 0, -32768, -8192, 1, 1'b0);
        chk("sat min count", 32'(ovf_count_b), 2);
        run1("min fits", -32768, 2, 0, -8192, -8192, 0, 1'b0);
        chk("min fits count", 32'(ovf_count_b), 2);
        chk("wide sticky", 32'(ovf_sticky_a), 0);
        @(negedge clk); clr_ovf = 1'b1;
        @(negedge clk); clr_ovf = 1'b0;
        chk("clr sticky", 32'(ovf_sticky_b), 0);
        chk("clr count", 32'(ovf_count_b), 0);
        run1("clr wins", 32767, 2, 1, 8192, 8191, 1, 1'b1);
        chk("clr wins sticky", 32'(ovf_sticky_b), 0);
        chk("clr wins count", 32'(ovf_count_b), 0);

        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            if (k >= 2) begin
                chk("rate vld", 32'(ifa.out_valid), 1);
                chk("rate data", $signed(ifa.out_data), te[k-2]);
            end
            if (k < 7) begin
                in_valid = 1'b1; in_data = 16'(td[k]); in_shift = 4'(ts[k]); in_mode = 2'(tm[k]);
            end else begin
                in_valid = 1'b0;
            end
        end
        @(negedge clk);
        chk("rate drained", 32'(ifa.out_valid), 0);

        in_shift = '0; in_mode = '0;
        mv1 = 1'b0; mv2 = 1'b0; held_v = 1'b0; held_d = 0; nsent = 0; nrecv = 0;
        for (int c = 0; c < 60 && nrecv < 6; c++) begin
            @(negedge clk);
            out_ready = pat[c % 8];
            in_valid  = (nsent < 6);
            in_data   = 16'(nsent + 1);
            #1;
            exp_rdy = !(mv1 && mv2 && !out_ready);
            chk("bp in_ready", 32'(ifa.in_ready), 32'(exp_rdy));
            chk("bp out_valid", 32'(ifa.out_valid), 32'(mv2));
            if (held_v) chk("bp hold", $signed(ifa.out_data), held_d);
            held_v = ifa.out_valid && !out_ready;
            held_d = $signed(ifa.out_data);
            if (ifa.out_valid && out_ready) begin
                chk("bp order", $signed(ifa.out_data), nrecv + 1);
                nrecv++;
            end
            if (in_valid && ifa.in_ready) nsent++;
            e2 = !mv2 || out_ready;
            e1 = !mv1 || e2;
            if (e2) mv2 = mv1;
            if (e1) mv1 = in_valid;
        end
        chk("bp received", nrecv, 6);
        @(negedge clk);
        out_ready = 1'b1; in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("bp no dup", 32'(ifa.out_valid), 0);

        @(negedge clk);
        in_valid = 1'b1; in_data = 16'(32767); in_shift = '0; in_mode = '0;
        @(negedge clk);
        in_data = 16'(5);
        @(negedge clk);
        in_valid = 1'b0;
        chk("flight vld", 32'(ifb.out_valid), 1);
        chk("flight count", 32'(ovf_count_b), 1);
        #2 reset_n = 1'b0;
        #1;
        chk("async vld", 32'(ifb.out_valid), 0);
        chk("async data", $signed(ifb.out_data), 0);
        chk("async sat", 32'(ifb.out_sat), 0);
        chk("async count", 32'(ovf_count_b), 0);
        chk("async sticky", 32'(ovf_sticky_b), 0);
        @(negedge clk); reset_n = 1'b1;
        @(negedge clk);
        chk("no stale", 32'(ifa.out_valid), 0);
        run1("after rst", 9, 0, 0, 9, 9, 0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end
endmodule
